// File: rtl/dmem_ctrl.sv
// Data memory controller: byte/half/word loads and stores, wait states, alignment faults.
// Optional macro DMEM_OOB_TRAP_EN: nonzero address bits above the index raise a fault.
//
// state | meaning
// IDLE  | waiting for ena; ready/fault from the last access visible here
// BUSY  | request latched, counting wait states, access on terminal count
module dmem_ctrl #(
   parameter int unsigned IDX_W       = 9,
   parameter int unsigned WAIT_CYCLES = 0,
   parameter int unsigned DEBUG_IDX   = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ena,
   input  logic        wena,
   input  logic [1:0]  mode,
   input  logic        sign_ext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        busy,
   output logic        fault,
   output logic [31:0] answer
);

   localparam int unsigned DEPTH = 1 << IDX_W;
   localparam logic [3:0] WAIT_LD = WAIT_CYCLES[3:0];
   localparam logic [IDX_W-1:0] DBG = DEBUG_IDX[IDX_W-1:0];

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  mode_q, mode_d;
   logic        wena_q, wena_d;
   logic        sext_q, sext_d;
   logic        ready_q, ready_d;
   logic        busy_q, busy_d;
   logic        fault_q, fault_d;

   logic [31:0] mem [DEPTH];

   logic [IDX_W-1:0] idx;
   logic [31:0]      rd_word;
   logic             is_half, is_byte, misalign, oob, bad;
   logic [7:0]       lane_b;
   logic [15:0]      lane_h;
   logic [31:0]      load_val;
   logic [3:0]       be;
   logic [31:0]      wr_word;
   logic             mem_we;

   assign idx     = addr_q[IDX_W+1:2];
   assign rd_word = mem[idx];
   assign is_half = (mode_q == 2'b01);
   assign is_byte = (mode_q == 2'b10);

`ifdef DMEM_OOB_TRAP_EN
   assign oob = |addr_q[31:IDX_W+2];
`else
   logic unused_hi;
   assign unused_hi = |addr_q[31:IDX_W+2];
   assign oob       = 1'b0;
`endif

   assign misalign = is_byte ? 1'b0 : (is_half ? addr_q[0] : |addr_q[1:0]);
   assign bad      = misalign | oob;

   always_comb begin
      lane_b   = rd_word[7:0];
      case (addr_q[1:0])
         2'd1:    lane_b = rd_word[15:8];
         2'd2:    lane_b = rd_word[23:16];
         2'd3:    lane_b = rd_word[31:24];
         default: lane_b = rd_word[7:0];
      endcase
      lane_h = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
      if (is_byte)
         load_val = {{24{sext_q & lane_b[7]}}, lane_b};
      else if (is_half)
         load_val = {{16{sext_q & lane_h[15]}}, lane_h};
      else
         load_val = rd_word;
   end

   // Store data is replicated across lanes so the byte enables alone pick the target.
   always_comb begin
      be      = 4'hF;
      wr_word = wdata_q;
      if (is_byte) begin
         be      = 4'b0001 << addr_q[1:0];
         wr_word = {4{wdata_q[7:0]}};
      end else if (is_half) begin
         be      = addr_q[1] ? 4'b1100 : 4'b0011;
         wr_word = {2{wdata_q[15:0]}};
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      mode_d  = mode_q;
      wena_d  = wena_q;
      sext_d  = sext_q;
      ready_d = 1'b0;
      busy_d  = busy_q;
      fault_d = fault_q;
      mem_we  = 1'b0;
      case (state_q)
         IDLE: begin
            if (ena) begin
               addr_d  = addr;
               wdata_d = wdata;
               mode_d  = mode;
               wena_d  = wena;
               sext_d  = sign_ext;
               cnt_d   = WAIT_LD;
               fault_d = 1'b0;
               busy_d  = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = IDLE;
               busy_d  = 1'b0;
               ready_d = 1'b1;
               if (bad) begin
                  fault_d = 1'b1;
                  rdata_d = 32'd0;
               end else if (wena_q) begin
                  mem_we = 1'b1;
               end else begin
                  rdata_d = load_val;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         mode_q  <= 2'd0;
         wena_q  <= 1'b0;
         sext_q  <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         mode_q  <= mode_d;
         wena_q  <= wena_d;
         sext_q  <= sext_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         fault_q <= fault_d;
      end
   end

   // Array has no reset; an abort is safe because mem_we depends on the reset state.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[idx][8*i +: 8] <= wr_word[8*i +: 8];
      end
   end

   assign rdata  = rdata_q;
   assign ready  = ready_q;
   assign busy   = busy_q;
   assign fault  = fault_q;
   assign answer = mem[DBG];

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: byte-array reference model, random and directed accesses.
module tb_dmem_ctrl;

   localparam int IDX_W = 9;
   localparam int WC    = 3;
   localparam int DBG   = 0;
   localparam int DEPTH = 1 << IDX_W;
   localparam int NB    = 4 * DEPTH;

   logic        clk, rst, ena, wena, sign_ext;
   logic [1:0]  mode;
   logic [31:0] addr, wdata, rdata, answer;
   logic        ready, busy, fault;

   dmem_ctrl #(.IDX_W(IDX_W), .WAIT_CYCLES(WC), .DEBUG_IDX(DBG)) dut (
      .clk(clk), .rst(rst), .ena(ena), .wena(wena), .mode(mode),
      .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .rdata(rdata),
      .ready(ready), .busy(busy), .fault(fault), .answer(answer)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] rd;
      logic        f;
   } exp_t;

   exp_t        q[$];
   logic [7:0]  mb [NB];
   logic [31:0] last_rd;
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] mword(input int i);
      return {mb[4*i+3], mb[4*i+2], mb[4*i+1], mb[4*i]};
   endfunction

   // Reference: memory as a flat byte array, access size in bytes, plain modular arithmetic.
   task automatic model(input logic we, input logic [1:0] md, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd, output exp_t e);
      int size, base;
      logic bad;
      logic [31:0] v;
      size = (md == 2'b01) ? 2 : (md == 2'b10) ? 1 : 4;
      base = int'(a % 32'(NB));
      bad  = (a % 32'(size)) != 0;
`ifdef DMEM_OOB_TRAP_EN
      bad  = bad || (a >= 32'(NB));
`endif
      e.f = bad;
      if (bad) begin
         last_rd = 32'd0;
      end else if (we) begin
         for (int i = 0; i < size; i++) mb[base+i] = wd[8*i +: 8];
      end else begin
         v = 32'd0;
         for (int i = 0; i < size; i++) v = v | (32'(mb[base+i]) << (8*i));
         if (sx && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
         last_rd = v;
      end
      e.rd = last_rd;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (ready === 1'b1) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_ready: got ready=1 expected no pending request");
         end else begin
            e = q.pop_front();
            check("rdata", rdata, e.rd);
            check("fault", {31'd0, fault}, {31'd0, e.f});
         end
      end
   end

   task automatic issue(input logic we, input logic [1:0] md, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd);
      exp_t e;
      ena = 1'b1; wena = we; mode = md; sign_ext = sx; addr = a; wdata = wd;
      model(we, md, sx, a, wd, e);
      q.push_back(e);
   endtask

   task automatic wait_done(input int lat0);
      int lat;
      lat = lat0;
      check("busy_while_pending", {31'd0, busy}, 32'd1);
      while (ready !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("latency", 32'(lat), 32'(WC + 1));
      check("busy_at_ready", {31'd0, busy}, 32'd0);
      check("answer", answer, mword(DBG));
   endtask

   task automatic do_req(input logic we, input logic [1:0] md, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd);
      @(negedge clk);
      issue(we, md, sx, a, wd);
      @(negedge clk);
      ena = 1'b0;
      wait_done(0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, d;
      logic [1:0]  md;
      rst = 1'b1; ena = 1'b0; wena = 1'b0; mode = 2'b00; sign_ext = 1'b0;
      addr = 32'd0; wdata = 32'd0; last_rd = 32'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_rdata", rdata, 32'd0);
      check("rst_ready", {31'd0, ready}, 32'd0);
      check("rst_busy",  {31'd0, busy},  32'd0);
      check("rst_fault", {31'd0, fault}, 32'd0);

      for (int i = 0; i < DEPTH; i++) do_req(1'b1, 2'b00, 1'b0, 32'(4*i), $urandom);

      do_req(1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF);
      do_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
      check("ld_word_10", rdata, 32'hDEADBEEF);
      do_req(1'b1, 2'b10, 1'b0, 32'h13, 32'h80);
      do_req(1'b0, 2'b10, 1'b1, 32'h13, 32'h0);
      check("ld_byte_sext", rdata, 32'hFFFFFF80);
      do_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
      check("ld_byte_zext", rdata, 32'h00000080);
      do_req(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
      check("ld_word_merged", rdata, 32'h80ADBEEF);
      do_req(1'b1, 2'b01, 1'b0, 32'h0, 32'hFFFF1234);
      check("answer_half", {16'd0, answer[15:0]}, 32'h1234);
      do_req(1'b0, 2'b01, 1'b1, 32'h1, 32'h0);
      check("misalign_fault", {31'd0, fault}, 32'd1);
      check("misalign_rdata", rdata, 32'd0);
      do_req(1'b1, 2'b00, 1'b0, 32'h2, 32'h11111111);
      do_req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0);

      do_req(1'b1, 2'b00, 1'b0, 32'h800, 32'hCAFEF00D);
      do_req(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);

      // ena pulses during BUSY must not start or queue another access
      @(negedge clk);
      issue(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
      @(negedge clk);
      ena = 1'b1; wena = 1'b1; mode = 2'b00; addr = 32'h10; wdata = 32'h12345678;
      @(negedge clk);
      @(negedge clk);
      ena = 1'b0;
      wait_done(2);
      repeat (3) @(negedge clk);
      do_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);

      // back-to-back: new request presented during the ready cycle
      @(negedge clk);
      issue(1'b1, 2'b00, 1'b0, 32'h40, 32'hA5A5_0F0F);
      @(negedge clk);
      ena = 1'b0;
      wait_done(0);
      issue(1'b0, 2'b01, 1'b1, 32'h42, 32'h0);
      @(negedge clk);
      ena = 1'b0;
      wait_done(0);
      check("b2b_half", rdata, 32'hFFFFA5A5);

      // reset during BUSY of a store aborts it
      @(negedge clk);
      ena = 1'b1; wena = 1'b1; mode = 2'b00; addr = 32'h20; wdata = 32'h55AA55AA;
      @(negedge clk);
      ena = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_rdata", rdata, 32'd0);
      check("abort_ready", {31'd0, ready}, 32'd0);
      check("abort_busy",  {31'd0, busy},  32'd0);
      check("abort_fault", {31'd0, fault}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      last_rd = 32'd0;
      repeat (8) @(negedge clk);
      do_req(1'b0, 2'b00, 1'b0, 32'h20, 32'h0);

      for (int n = 0; n < 300; n++) begin
         md = 2'($urandom_range(0, 3));
         a  = 32'($urandom_range(0, NB - 1));
         if ($urandom_range(0, 3) != 0)
            a = (md == 2'b01) ? (a & ~32'd1) : (md == 2'b10) ? a : (a & ~32'd3);
         if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFF_F800);
         d = $urandom;
         do_req(1'($urandom_range(0, 1)), md, 1'($urandom_range(0, 1)), a, d);
      end

      repeat (4) @(negedge clk);
      check("queue_drained", 32'(q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
